// File: rtl/conv_window_addr_gen_if.sv
// Window-address bus between the layer sequencer, the address generator and the line-buffer read ports.
// The generator takes the master side; the sequencer/consumer pair takes the slave side.
interface conv_window_addr_gen_if #(
  parameter int ADDR_W   = 13,
  parameter int NUM_ROWS = 3,
  parameter int RW       = 5,
  parameter int CW       = 8
);
  logic                       start;
  logic                       out_ready;
  logic                       out_valid;
  logic [NUM_ROWS*ADDR_W-1:0] addr;
  logic [RW-1:0]              row_idx;
  logic [CW-1:0]              col_idx;
  logic                       last_col;
  logic                       last;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, out_ready,
    output out_valid, addr, row_idx, col_idx, last_col, last, busy, done
  );

  modport slave (
    output start, out_ready,
    input  out_valid, addr, row_idx, col_idx, last_col, last, busy, done
  );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Sliding-window read-address generator: walks ROWS x COLS output positions and presents
// NUM_ROWS line-buffer addresses per window over a valid/ready handshake.
module conv_window_addr_gen #(
  parameter int ADDR_W      = 13,
  parameter int NUM_ROWS    = 3,
  parameter int ROWS        = 18,
  parameter int COLS        = 159,
  parameter int LINE_STRIDE = 160,
  parameter int COL_STEP    = 8,
  parameter int ROW_STEP    = 160,
  parameter int BASE        = 0
) (
  input logic clk,
  input logic reset,
  conv_window_addr_gen_if.master win
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(COLS - 1);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] COL_STEP_A = ADDR_W'(COL_STEP);
  localparam logic [ADDR_W-1:0] ROW_STEP_A = ADDR_W'(ROW_STEP);

  logic [1:0]        state, state_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic [ADDR_W-1:0] col_base, col_base_nxt;
  logic              accept;

  // Kernel row k sits LINE_STRIDE*k above the window's base; sums wrap modulo 2^ADDR_W.
  function automatic logic [NUM_ROWS*ADDR_W-1:0] window_addr(input logic [ADDR_W-1:0] base);
    logic [NUM_ROWS*ADDR_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      v[k*ADDR_W +: ADDR_W] = base + ADDR_W'(k * LINE_STRIDE);
    end
    return v;
  endfunction

  assign accept = win.out_valid && win.out_ready;

  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    col_nxt      = col;
    row_base_nxt = row_base;
    col_base_nxt = col_base;
    case (state)
      S_IDLE: begin
        if (win.start) begin
          state_nxt    = S_RUN;
          row_nxt      = '0;
          col_nxt      = '0;
          row_base_nxt = BASE_A;
          col_base_nxt = BASE_A;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (col != COL_LAST) begin
            col_nxt      = col + CW'(1);
            col_base_nxt = col_base + COL_STEP_A;
          end else if (row != ROW_LAST) begin
            // New output row restarts from the row origin, not from the last column.
            col_nxt      = '0;
            row_nxt      = row + RW'(1);
            row_base_nxt = row_base + ROW_STEP_A;
            col_base_nxt = row_base + ROW_STEP_A;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are computed from next-state values so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      row           <= '0;
      col           <= '0;
      row_base      <= '0;
      col_base      <= '0;
      win.out_valid <= 1'b0;
      win.addr      <= '0;
      win.row_idx   <= '0;
      win.col_idx   <= '0;
      win.last_col  <= 1'b0;
      win.last      <= 1'b0;
      win.busy      <= 1'b0;
      win.done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      row           <= row_nxt;
      col           <= col_nxt;
      row_base      <= row_base_nxt;
      col_base      <= col_base_nxt;
      win.out_valid <= (state_nxt == S_RUN);
      win.busy      <= (state_nxt != S_IDLE);
      win.done      <= (state_nxt == S_DONE);
      win.row_idx   <= row_nxt;
      win.col_idx   <= col_nxt;
      win.last_col  <= (state_nxt == S_RUN) && (col_nxt == COL_LAST);
      win.last      <= (state_nxt == S_RUN) && (col_nxt == COL_LAST) && (row_nxt == ROW_LAST);
      if (state_nxt == S_RUN) begin
        win.addr <= window_addr(col_base_nxt);
      end
    end
  end
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: default map, wrap-around base and single-window map,
// checked against a closed-form address model and a table of known window addresses.
module tb_conv_window_addr_gen;
  localparam int ROWS  = 18;
  localparam int COLS  = 159;
  localparam int NBEAT = ROWS * COLS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  conv_window_addr_gen_if #(.ADDR_W(13), .NUM_ROWS(3), .RW(5), .CW(8)) s0 ();
  conv_window_addr_gen_if #(.ADDR_W(13), .NUM_ROWS(3), .RW(5), .CW(8)) s1 ();
  conv_window_addr_gen_if #(.ADDR_W(13), .NUM_ROWS(3), .RW(1), .CW(1)) s2 ();

  conv_window_addr_gen #(.ADDR_W(13), .NUM_ROWS(3), .ROWS(18), .COLS(159), .LINE_STRIDE(160),
    .COL_STEP(8), .ROW_STEP(160), .BASE(0)) dut0 (.clk(clk), .reset(reset), .win(s0.master));
  conv_window_addr_gen #(.ADDR_W(13), .NUM_ROWS(3), .ROWS(18), .COLS(159), .LINE_STRIDE(160),
    .COL_STEP(8), .ROW_STEP(160), .BASE(8000)) dut1 (.clk(clk), .reset(reset), .win(s1.master));
  conv_window_addr_gen #(.ADDR_W(13), .NUM_ROWS(3), .ROWS(1), .COLS(1), .LINE_STRIDE(160),
    .COL_STEP(8), .ROW_STEP(160), .BASE(0)) dut2 (.clk(clk), .reset(reset), .win(s2.master));

  typedef struct {
    int r; int c; int a0; int a1; int a2; bit lc; bit l;
  } vec_t;
  vec_t tbl [6];
  logic [63:0] cap [NBEAT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window (r,c), kernel row k lives at BASE + r*ROW_STEP + c*COL_STEP + k*LINE_STRIDE mod 8192.
  function automatic logic [38:0] model_addr(input int base, input int r, input int c);
    logic [38:0] v;
    for (int k = 0; k < 3; k++) v[k*13 +: 13] = 13'((base + r*160 + c*8 + k*160) % 8192);
    return v;
  endfunction

  function automatic logic [63:0] snap0();
    return {7'd0, s0.out_valid, s0.busy, s0.done, s0.last_col, s0.last,
            s0.row_idx, s0.col_idx, s0.addr};
  endfunction

  function automatic logic [63:0] expv(input bit v, input bit b, input bit d, input bit lc,
                                       input bit l, input int r, input int c, input logic [38:0] a);
    return {7'd0, v, b, d, lc, l, 5'(r), 8'(c), a};
  endfunction

  // mode 0: ready held high (captures beats); 1: random ready and stray starts; 2: 5-cycle stall at col 40.
  task automatic run_map(input int mode);
    int r = 0, c = 0, beats = 0, stall = 0, cyc = 0;
    bit fin = 0;
    bit rdy;
    bit lc, l;
    s0.start = 1'b1;
    @(negedge clk);
    s0.start = 1'b0;
    while (!fin && cyc < 20000) begin
      lc = (c == COLS - 1);
      l  = lc && (r == ROWS - 1);
      check("beat", snap0(), expv(1, 1, 0, lc, l, r, c, model_addr(0, r, c)));
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
        s0.start = ($urandom_range(0, 7) == 0);
      end else if (mode == 2 && r == 0 && c == 40) begin
        check("stall_k0", 64'(s0.addr[12:0]), 64'd320);
        if (stall < 5) begin
          rdy = 1'b0;
          stall++;
        end
      end
      s0.out_ready = rdy;
      if (rdy) begin
        if (mode == 0) cap[beats] = snap0();
        beats++;
        if (l) fin = 1'b1;
        else if (lc) begin c = 0; r++; end
        else c++;
      end
      cyc++;
      @(negedge clk);
    end
    s0.start = 1'b0;
    s0.out_ready = 1'b0;
    check("map_finished", 64'(fin), 64'd1);
    check("beat_count", 64'(beats), 64'(NBEAT));
    check("done_cycle", {61'd0, s0.out_valid, s0.busy, s0.done}, 64'b011);
    s0.start = 1'b1;
    @(negedge clk);
    s0.start = 1'b0;
    check("after_done", {61'd0, s0.out_valid, s0.busy, s0.done}, 64'b000);
    check("final_idx", {51'd0, s0.row_idx, s0.col_idx}, {51'd0, 5'd17, 8'd158});
  endtask

  initial begin
    tbl[0] = '{0,   0,    0,  160,  320, 1'b0, 1'b0};
    tbl[1] = '{0,   1,    8,  168,  328, 1'b0, 1'b0};
    tbl[2] = '{0, 158, 1264, 1424, 1584, 1'b1, 1'b0};
    tbl[3] = '{1,   0,  160,  320,  480, 1'b0, 1'b0};
    tbl[4] = '{5,  40, 1120, 1280, 1440, 1'b0, 1'b0};
    tbl[5] = '{17, 158, 3984, 4144, 4304, 1'b1, 1'b1};

    reset = 1'b1;
    s0.start = 1'b0; s0.out_ready = 1'b0;
    s1.start = 1'b0; s1.out_ready = 1'b0;
    s2.start = 1'b0; s2.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_d0", snap0(), 64'd0);
    check("reset_d2", {59'd0, s2.out_valid, s2.busy, s2.done, s2.last_col, s2.last}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_d0", snap0(), 64'd0);

    run_map(0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("table_%0d_%0d", tbl[i].r, tbl[i].c), cap[tbl[i].r * COLS + tbl[i].c],
            expv(1, 1, 0, tbl[i].lc, tbl[i].l, tbl[i].r, tbl[i].c,
                 {13'(tbl[i].a2), 13'(tbl[i].a1), 13'(tbl[i].a0)}));
    end
    run_map(1);
    run_map(2);

    // Abandon a map at row 5 with reset.
    begin
      int cyc = 0;
      s0.out_ready = 1'b1;
      s0.start = 1'b1;
      @(negedge clk);
      s0.start = 1'b0;
      while (s0.row_idx != 5'd5 && cyc < 2000) begin
        cyc++;
        @(negedge clk);
      end
      check("reach_row5", 64'(s0.row_idx), 64'd5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid", snap0(), 64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_done_after_reset", {62'd0, s0.out_valid, s0.done}, 64'd0);
      end
      s0.out_ready = 1'b0;
    end
    run_map(1);

    // Base near the top of the address space wraps kernel row 2.
    s1.start = 1'b1;
    @(negedge clk);
    s1.start = 1'b0;
    check("wrap_first", {25'd0, s1.out_valid, s1.addr}, {25'd0, 1'b1, 13'd128, 13'd8160, 13'd8000});
    @(negedge clk);
    check("wrap_hold", {25'd0, s1.out_valid, s1.addr}, {25'd0, 1'b1, 13'd128, 13'd8160, 13'd8000});

    // Single-window map.
    s2.start = 1'b1;
    s2.out_ready = 1'b1;
    @(negedge clk);
    s2.start = 1'b0;
    check("one_beat", {20'd0, s2.out_valid, s2.busy, s2.done, s2.last_col, s2.last,
                       s2.row_idx, s2.col_idx, s2.addr},
          {20'd0, 5'b11011, 1'b0, 1'b0, 13'd320, 13'd160, 13'd0});
    @(negedge clk);
    check("one_done", {61'd0, s2.out_valid, s2.busy, s2.done}, 64'b011);
    @(negedge clk);
    check("one_idle", {61'd0, s2.out_valid, s2.busy, s2.done}, 64'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Parametrised sliding-window read-address generator for the convolution line buffers. On a start pulse it walks an output feature map of ROWS × COLS window positions and, for each position, presents NUM_ROWS line-buffer addresses (one per kernel row) through a valid/ready handshake. It sits between the layer sequencer, which issues start and consumes done, and the line-buffer read ports, which consume the address bus. It supports back-pressure, arbitrary kernel height, configurable column and row steps, and a programmable base address.

## Interface
- ADDR_W, 13, address width; all address arithmetic is modulo 2^ADDR_W
- NUM_ROWS, 3, kernel rows, i.e. number of addresses emitted per window
- ROWS, 18, output rows per map (≥1)
- COLS, 159, output columns per row (≥1)
- LINE_STRIDE, 160, address distance between kernel rows k and k+1
- COL_STEP, 8, address advance per column
- ROW_STEP, 160, address advance per output row
- BASE, 0, address of window (0,0), kernel row 0
- RW = max(1,$clog2(ROWS)), CW = max(1,$clog2(COLS)), derived
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- start  in  1  one-cycle request to begin a map; honoured only in IDLE
- out_ready  in  1  downstream accepts the current window
- out_valid  out  1  addr/row_idx/col_idx are valid
- addr  out  NUM_ROWS*ADDR_W  kernel row k occupies bits [k*ADDR_W +: ADDR_W]
- row_idx  out  RW  current output row
- col_idx  out  CW  current output column
- last_col  out  1  col_idx == COLS-1 while out_valid
- last  out  1  final window of map (row ROWS-1, col COLS-1) while out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final window accepted

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: out_valid=0. On start, load row=0, col=0, row_base=BASE, col_base=BASE, then go to RUN.
- RUN: out_valid=1, and addr[k] = col_base + k*LINE_STRIDE (mod 2^ADDR_W).
- A beat is accepted when out_valid && out_ready. Without acceptance, every output holds stable.
- On acceptance, not last_col: col+1, col_base += COL_STEP.
- On acceptance, last_col and not last: col=0, row+1, row_base += ROW_STEP, col_base = row_base + ROW_STEP.
- On acceptance, last: go to DONE, with out_valid=0 the next cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE. Counters and indices keep their final values.
- start is ignored in RUN and DONE. start in the DONE cycle is also ignored.
- Degenerate sizes: ROWS=1 and/or COLS=1 are legal. With ROWS=COLS=1, the map is a single beat with last=last_col=1.
- Address overflow wraps silently; no error flag.

## Timing
- Reset values: out_valid=0, addr=0, row_idx=0, col_idx=0, last_col=0, last=0, busy=0, done=0, state IDLE. Reset overrides all other inputs, including mid-map; any map in progress is abandoned with no done.
- start in cycle n makes out_valid and busy high in cycle n+1.
- Throughput is one window per cycle while out_ready=1. A map with out_ready tied high takes ROWS*COLS RUN cycles.
- If the last beat is accepted in cycle m: out_valid=0 and done=1 in cycle m+1, busy=0 in cycle m+2.
- The earliest accepted restart is start in cycle m+2, which gives out_valid in cycle m+3.

## Test plan
- Default params, start with out_ready=1 → first beat addr={320,160,0}. Next beat {328,168,8}. Column 158 gives kernel row 0 = 1264 with last_col=1.
- Default params, full map → exactly 2862 accepted beats. Final beat has row_idx=17, col_idx=158, addr={4304,4144,3984}, last=1. done pulses once, the cycle after that beat.
- Back-pressure: drop out_ready for 5 cycles at column 40 → addr/indices frozen at col 40 (kernel row 0 = 320). The sequence resumes with no skipped or duplicated beats.
- Wrap: BASE=8000, ADDR_W=13 → first beat kernel rows {8000, 8160, 128}.
- Assert reset at row 5 → next cycle all outputs 0 and no done pulse. A following start restarts at addr {320,160,0}.
- Start pulses while busy and on the done cycle are ignored. ROWS=1, COLS=1 gives one beat, then done.
